// File: rtl/serial_full_subtractor.sv
`default_nettype none
// ============================================================================
// serial_full_subtractor : bit-serial a - b - bin, LSB first, one cell/clock
// Revision: 1.0
// ============================================================================
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             enable,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;

  // Single full-subtractor cell on the operand LSBs
  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !enable) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // enable is active-low; a high level freezes everything
          if (!enable) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_next;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == c_last) begin
              r_state <= S_DONE;
              r_diff  <= w_res_next;
              r_bout  <= w_br_next;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule
`default_nettype wire
